// File: rtl/div_pkg.sv
// Shared types and constants for the iterative divider that feeds the regfile write port.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CALC  = 2'd1,
    FIXUP = 2'd2,
    WB    = 2'd3
  } div_state_t;

  localparam int OP_SIGNED_BIT = 0;
  localparam int OP_REM_BIT    = 1;

  localparam logic [4:0] XZR = 5'd31;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift in the next dividend bit, compare, subtract.
module div_step
  import div_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] dvsr,
  output logic [WIDTH-1:0] rem_next,
  output logic [WIDTH-1:0] quo_next
);

  logic [WIDTH:0] shifted_s;
  logic [WIDTH:0] diff_s;

  // Bit WIDTH of the difference is the borrow: set exactly when shifted < dvsr.
  always_comb begin
    shifted_s = {rem, quo[WIDTH-1]};
    diff_s    = shifted_s - {1'b0, dvsr};
    if (diff_s[WIDTH]) begin
      rem_next = shifted_s[WIDTH-1:0];
    end else begin
      rem_next = diff_s[WIDTH-1:0];
    end
    quo_next = {quo[WIDTH-2:0], ~diff_s[WIDTH]};
  end

endmodule

// File: rtl/seq_div_wb.sv
// Iterative UDIV/SDIV/UREM/SREM unit that writes its result straight into the regfile port,
// yielding to the pipeline's own writeback through wb_grant.
module seq_div_wb
  import div_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic [4:0]       dest,
  output logic             busy,
  input  logic             wb_grant,
  output logic             we3,
  output logic [4:0]       wa3,
  output logic [WIDTH-1:0] wd3,
  output logic             done
);

  div_state_t       state_r, state_nxt_s;
  logic [CNT_W-1:0] cnt_r;
  logic [WIDTH-1:0] rem_r, quo_r, dvsr_r, dvnd_r;
  logic [4:0]       dest_r;
  logic             rem_op_r, neg_q_r, neg_r_r, dvz_r;
  logic             busy_r, we3_r, done_r;
  logic [4:0]       wa3_r;
  logic [WIDTH-1:0] wd3_r;

  logic [WIDTH-1:0] rem_step_s, quo_step_s;
  logic             dvnd_neg_s, dvsr_neg_s;
  logic [WIDTH-1:0] q_res_s, r_res_s, result_s;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem      (rem_r),
    .quo      (quo_r),
    .dvsr     (dvsr_r),
    .rem_next (rem_step_s),
    .quo_next (quo_step_s)
  );

  assign dvnd_neg_s = op[OP_SIGNED_BIT] & dividend[WIDTH-1];
  assign dvsr_neg_s = op[OP_SIGNED_BIT] & divisor[WIDTH-1];

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state decode.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_nxt_s = (divisor == '0) ? FIXUP : CALC;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      CALC: begin
        if (cnt_r == CNT_W'(1)) begin
          state_nxt_s = FIXUP;
        end else begin
          state_nxt_s = CALC;
        end
      end
      FIXUP: begin
        if (dest_r == XZR) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = WB;
        end
      end
      WB: begin
        if (wb_grant) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = WB;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Sign fixup; MIN/-1 comes out right because negating MIN wraps back to MIN.
  always_comb begin
    if (dvz_r) begin
      q_res_s = '0;
      r_res_s = dvnd_r;
    end else begin
      q_res_s = neg_q_r ? -quo_r : quo_r;
      r_res_s = neg_r_r ? -rem_r : rem_r;
    end
    if (rem_op_r) begin
      result_s = r_res_s;
    end else begin
      result_s = q_res_s;
    end
  end

  // Operand capture and the per-cycle shift/subtract datapath.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_r    <= '0;
      rem_r    <= '0;
      quo_r    <= '0;
      dvsr_r   <= '0;
      dvnd_r   <= '0;
      dest_r   <= 5'd0;
      rem_op_r <= 1'b0;
      neg_q_r  <= 1'b0;
      neg_r_r  <= 1'b0;
      dvz_r    <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            cnt_r    <= CNT_W'(WIDTH);
            rem_r    <= '0;
            quo_r    <= dvnd_neg_s ? -dividend : dividend;
            dvsr_r   <= dvsr_neg_s ? -divisor : divisor;
            dvnd_r   <= dividend;
            dest_r   <= dest;
            rem_op_r <= op[OP_REM_BIT];
            neg_q_r  <= dvnd_neg_s ^ dvsr_neg_s;
            neg_r_r  <= dvnd_neg_s;
            dvz_r    <= (divisor == '0);
          end
        end
        CALC: begin
          rem_r <= rem_step_s;
          quo_r <= quo_step_s;
          cnt_r <= cnt_r - CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  // Registered handshake and write-port outputs; wa3/wd3 keep their last value outside WB.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy_r <= 1'b0;
      we3_r  <= 1'b0;
      done_r <= 1'b0;
      wa3_r  <= 5'd0;
      wd3_r  <= '0;
    end else begin
      busy_r <= (state_nxt_s != IDLE);
      done_r <= 1'b0;
      case (state_r)
        FIXUP: begin
          if (dest_r == XZR) begin
            done_r <= 1'b1;
          end else begin
            we3_r <= 1'b1;
            wa3_r <= dest_r;
            wd3_r <= result_s;
          end
        end
        WB: begin
          if (wb_grant) begin
            we3_r  <= 1'b0;
            done_r <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = busy_r;
  assign we3  = we3_r;
  assign wa3  = wa3_r;
  assign wd3  = wd3_r;
  assign done = done_r;

endmodule
